// File: rtl/sdram_word_ctrl.sv
// 32-bit word front end for the 16-bit sdram command port: splits each word request into
// low-then-high half-word commands and uses read-modify-write for byte-partial halves.
module sdram_word_ctrl #(
   parameter logic [31:0] CMD_ADDR_OFFSET = 32'h0
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_wen,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   input  logic [3:0]  i_req_wstrb,
   output logic        o_resp_valid,
   input  logic        i_resp_ready,
   output logic [31:0] o_resp_rdata,
   output logic        o_cmd_valid,
   output logic        o_cmd_wen,
   output logic [31:0] o_cmd_addr,
   output logic [15:0] o_cmd_wdata,
   input  logic [15:0] i_cmd_rdata
);

   typedef enum logic [2:0] {
      StIdle, StRd0, StRd1, StRd2, StWr, StRmwRd, StRmwWr, StResp
   } state_t;

   state_t      r_state, w_next_state;
   logic        r_half, w_next_half;
   logic [31:0] r_base;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic [31:0] r_rdata;

   logic        w_accept;
   logic        w_half_sel;
   logic [1:0]  w_m;
   logic [15:0] w_wr_half;
   logic [15:0] w_merged;
   logic [31:0] w_half_addr;

   // A half with any strobe set needs a command; only a full pair avoids the read.
   function automatic state_t half_state(input logic [1:0] m);
      return (m == 2'b11) ? StWr : StRmwRd;
   endfunction

   assign w_accept    = i_req_valid && (r_state == StIdle);
   assign w_half_sel  = (r_state == StRd1) ? 1'b1 : (r_state == StRd0) ? 1'b0 : r_half;
   assign w_half_addr = r_base + {30'd0, w_half_sel, 1'b0};
   assign w_m         = r_half ? r_wstrb[3:2] : r_wstrb[1:0];
   assign w_wr_half   = r_half ? r_wdata[31:16] : r_wdata[15:0];
   assign w_merged    = {w_m[1] ? w_wr_half[15:8] : i_cmd_rdata[15:8],
                         w_m[0] ? w_wr_half[7:0]  : i_cmd_rdata[7:0]};
   assign o_resp_rdata = r_rdata;

   always_comb begin
      w_next_state = r_state;
      w_next_half  = r_half;
      o_req_ready  = 1'b0;
      o_resp_valid = 1'b0;
      o_cmd_valid  = 1'b0;
      o_cmd_wen    = 1'b0;
      o_cmd_addr   = 32'd0;
      o_cmd_wdata  = 16'd0;
      unique case (r_state)
         StIdle: begin
            o_req_ready = 1'b1;
            if (i_req_valid) begin
               w_next_half = 1'b0;
               if (!i_req_wen) begin
                  w_next_state = StRd0;
               end else if (i_req_wstrb[1:0] != 2'b00) begin
                  w_next_state = half_state(i_req_wstrb[1:0]);
               end else if (i_req_wstrb[3:2] != 2'b00) begin
                  w_next_state = half_state(i_req_wstrb[3:2]);
                  w_next_half  = 1'b1;
               end else begin
                  w_next_state = StResp;
               end
            end
         end
         StRd0: begin
            o_cmd_valid  = 1'b1;
            o_cmd_addr   = w_half_addr;
            w_next_state = StRd1;
         end
         StRd1: begin
            o_cmd_valid  = 1'b1;
            o_cmd_addr   = w_half_addr;
            w_next_state = StRd2;
         end
         StRd2: w_next_state = StResp;
         StRmwRd: begin
            o_cmd_valid  = 1'b1;
            o_cmd_addr   = w_half_addr;
            w_next_state = StRmwWr;
         end
         StWr, StRmwWr: begin
            o_cmd_valid = 1'b1;
            o_cmd_wen   = 1'b1;
            o_cmd_addr  = w_half_addr;
            o_cmd_wdata = (r_state == StWr) ? w_wr_half : w_merged;
            if (!r_half && (r_wstrb[3:2] != 2'b00)) begin
               w_next_state = half_state(r_wstrb[3:2]);
               w_next_half  = 1'b1;
            end else begin
               w_next_state = StResp;
            end
         end
         StResp: begin
            o_resp_valid = 1'b1;
            if (i_resp_ready) w_next_state = StIdle;
         end
         default: w_next_state = StIdle;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= StIdle;
         r_half  <= 1'b0;
         r_base  <= 32'd0;
         r_wdata <= 32'd0;
         r_wstrb <= 4'd0;
         r_rdata <= 32'd0;
      end else begin
         r_state <= w_next_state;
         r_half  <= w_next_half;
         if (w_accept) begin
            r_base  <= (i_req_addr - CMD_ADDR_OFFSET) & ~32'd3;
            r_wdata <= i_req_wdata;
            r_wstrb <= i_req_wstrb;
            r_rdata <= 32'd0;
         end
         // Read data returns one cycle after each read command.
         if (r_state == StRd1) r_rdata[15:0]  <= i_cmd_rdata;
         if (r_state == StRd2) r_rdata[31:16] <= i_cmd_rdata;
      end
   end

endmodule

// File: doc/sdram_word_ctrl.md
Name: sdram_word_ctrl

Overview:
Sequencing controller in front of the 16-bit sdram command model (`sdram_cmd`: valid/wen/addr/wdata in, registered rdata out one cycle after a read).
- Accepts one 32-bit word request at a time on a valid/ready interface with byte strobes.
- Splits each request into ordered 16-bit half-word commands, low half first.
- Implements partial-half writes as read-modify-write.
- Returns one response per request on a valid/ready channel.

Parameters:
CMD_ADDR_OFFSET, 32'h0, subtracted from req_addr before forming cmd_addr (maps the bus window base to sdram address 0)

Ports:
clock  in  1  system clock; all state on posedge
reset  in  1  asynchronous, active-high; clears all state
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_wen  in  1  1 = write, 0 = read
req_addr  in  32  byte address; bits [1:0] ignored (word aligned)
req_wdata  in  32  write data
req_wstrb  in  4  byte enables, bit i covers req_wdata[8i+7:8i]
resp_valid  out  1  response present
resp_ready  in  1  response consumed
resp_rdata  out  32  read data; 0 for writes
cmd_valid  out  1  to sdram_cmd valid
cmd_wen  out  1  to sdram_cmd wen
cmd_addr  out  32  to sdram_cmd addr, byte address of the half-word
cmd_wdata  out  16  to sdram_cmd wdata
cmd_rdata  in  16  from sdram_cmd rdata; valid the cycle after a read issue

Behaviour:
Reset values:
- State IDLE; req_ready=1; resp_valid=0; resp_rdata=0.
- cmd_valid=0, cmd_wen=0, cmd_addr=0, cmd_wdata=0.

Addressing:
- base = (req_addr - CMD_ADDR_OFFSET) & ~3, truncated to 32 bits (wraps).
- Half h in {0,1} uses cmd_addr = base + 2h.

Request capture:
- req_ready=1 only in IDLE.
- On req_valid & req_ready, latch wen, base, wdata, wstrb.
- cmd_* outputs are functions of state and latched values only; there is no combinational path from req_* or resp_ready to cmd_*.
- When cmd_valid=0, cmd_wen, cmd_addr and cmd_wdata are 0.

Read sequence (accept edge = cycle 0):
- RD0 (cycle 1): cmd read, half 0.
- RD1 (cycle 2): cmd read, half 1; capture cmd_rdata into rdata[15:0].
- RD2 (cycle 3): no cmd; capture cmd_rdata into rdata[31:16].
- RESP (cycle 4+): resp_valid=1.
- Exactly 2 commands per read.

Write sequence, per half h=0 then h=1, with m = wstrb[2h+1:2h]:
- m=00: skip; no command.
- m=11: WR state, one cycle; cmd write, data = wdata half.
- m=01 or 10:
  - RMW_RD: cmd read of the half.
  - RMW_WR (next cycle): cmd write; merged = per byte, wdata byte if strobe set, else the cmd_rdata byte.
- After half 1 (or immediately if wstrb=0000): RESP with resp_rdata=0.
- wstrb=0000 issues no commands; RESP is reached in cycle 1.

RESP handling:
- resp_valid and resp_rdata are held stable until resp_ready.
- On resp_valid & resp_ready, go to IDLE and set resp_valid=0 on the next edge.
- req_ready rises in that cycle; there is no accept in the RESP cycle itself.

Boundary conditions:
- Back-to-back requests: minimum spacing is one IDLE cycle between the handshake edge and the next accept.
- resp_ready held high: RESP lasts exactly 1 cycle.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values.
  - The request in flight is dropped with no response.
  - A partially issued write is not completed or rolled back.
- cmd_rdata is sampled only in RD1, RD2 and RMW_WR and ignored otherwise.

Test Plan:
- Model: a sdram_cmd-equivalent memory model is attached to the cmd_* ports for all scenarios below.
- Read, CMD_ADDR_OFFSET=0, memory[0x100]=16'h1234, [0x102]=16'hABCD; read addr 0x101 -> cmd reads at 0x100 (cycle 1), 0x102 (cycle 2); resp_valid in cycle 4 with resp_rdata=32'hABCD1234.
- Full write: addr 0x200, wdata 32'hDEADBEEF, wstrb 1111 -> exactly two commands: write 0x200=BEEF, write 0x202=DEAD; resp_rdata=0.
- Partial write: memory[0x300]=16'h1122, [0x302]=16'h3344; addr 0x300, wdata 32'hAABBCCDD, wstrb 0100:
  - Half 0 skipped.
  - Half 1: read 0x302, then write 0x302=16'h33BB.
  - Final memory words: 1122 / 33BB.
- wstrb=0000 write: no cmd_valid pulse at all; resp_valid in cycle 1.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid and resp_rdata stable, req_ready=0, no cmd_valid; then one handshake -> IDLE.
- Reset mid-op: assert reset in RMW_WR cycle -> same edge: cmd_valid=0, resp_valid=0, req_ready=1; then a fresh read completes normally. Offset: CMD_ADDR_OFFSET=32'h8000_0000, read addr 32'h8000_0010 -> cmd_addr 0x10 and 0x12.
